// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the command-master FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_LAST = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

endpackage

// File: rtl/ahb_addr_gen.sv
// Beat counter and address incrementer; the address wraps modulo 2^AWIDTH.
module ahb_addr_gen #(
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned LENW   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [LENW-1:0]   len_i,
  input  logic [2:0]        size_i,
  input  logic              step_i,
  output logic [AWIDTH-1:0] addr_o,
  output logic              last_o
);

  logic [AWIDTH-1:0] addr_q, addr_d, incr;
  logic [LENW-1:0]   cnt_q, cnt_d;

  always_comb begin
    incr   = AWIDTH'(1) << size_i;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = addr_i;
      cnt_d  = len_i;
    end else if (step_i && (cnt_q != '0)) begin
      addr_d = addr_q + incr;
      cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/ahb_cmd_master.sv
// Command-driven AHB-Lite master: one SINGLE/INCR command at a time with
// pipelined address/data phases, streamed write/read data and per-command status.
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned LENW   = 4
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [AWIDTH-1:0] CMD_ADDR,
  input  logic [2:0]        CMD_SIZE,
  input  logic [LENW-1:0]   CMD_LEN,
  input  logic [31:0]       WR_DATA,
  input  logic              WR_VALID,
  output logic              WR_READY,
  output logic [31:0]       RD_DATA,
  output logic              RD_VALID,
  output logic              RSP_DONE,
  output logic              RSP_ERR,
  output logic              HSEL,
  output logic [AWIDTH-1:0] HADDR,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;
  logic        burst_q, burst_d;
  logic        first_q, first_d;
  logic        held_q, held_d;
  logic        dphase_q, dphase_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rsp_done_q, rsp_done_d;
  logic        rsp_err_q, rsp_err_d;

  htrans_e           htrans;
  logic              err1, beat_rdy, addr_acc, wr_pop;
  logic              ag_load, ag_step, ag_last;
  logic [AWIDTH-1:0] ag_addr;

  ahb_addr_gen #(
    .AWIDTH(AWIDTH),
    .LENW  (LENW)
  ) u_addr_gen (
    .clk_i (HCLK),
    .rst_ni(HRESETN),
    .load_i(ag_load),
    .addr_i(CMD_ADDR),
    .len_i (CMD_LEN),
    .size_i(size_q),
    .step_i(ag_step),
    .addr_o(ag_addr),
    .last_o(ag_last)
  );

  // First ERROR cycle cancels the pending address phase combinationally.
  assign err1     = dphase_q && HRESP && !HREADY;
  // A held (waited) address phase already owns its popped write beat.
  assign beat_rdy = held_q || !write_q || WR_VALID;

  always_comb begin
    htrans = HTRANS_IDLE;
    if ((state_q == ST_ADDR) && !err1) begin
      if (beat_rdy)      htrans = first_q ? HTRANS_NONSEQ : HTRANS_SEQ;
      else if (!first_q) htrans = HTRANS_BUSY;
    end
  end

  assign addr_acc = ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ)) && HREADY;
  assign wr_pop   = (state_q == ST_ADDR) && write_q && !held_q && WR_VALID && !err1;

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    burst_d    = burst_q;
    first_d    = first_q;
    wbuf_d     = wbuf_q;
    hwdata_d   = hwdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rsp_done_d = 1'b0;
    rsp_err_d  = 1'b0;
    ag_load    = 1'b0;
    ag_step    = 1'b0;
    held_d     = ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ)) && !HREADY;
    dphase_d   = HREADY ? addr_acc : dphase_q;

    if (wr_pop) wbuf_d = WR_DATA;
    if (addr_acc && write_q) hwdata_d = held_q ? wbuf_q : WR_DATA;
    if (dphase_q && HREADY && !HRESP && !write_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = HRDATA;
    end

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          write_d = CMD_WRITE;
          size_d  = CMD_SIZE;
          burst_d = (CMD_LEN != '0);
          first_d = 1'b1;
          ag_load = 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (err1) begin
          state_d = ST_ERR;
        end else if (addr_acc) begin
          first_d = 1'b0;
          if (ag_last) state_d = ST_LAST;
          else         ag_step = 1'b1;
        end
      end
      ST_LAST: begin
        if (err1) begin
          state_d = ST_ERR;
        end else if (HREADY) begin
          state_d    = ST_IDLE;
          rsp_done_d = 1'b1;
          rsp_err_d  = HRESP;
        end
      end
      ST_ERR: begin
        if (HREADY) begin
          state_d    = ST_IDLE;
          rsp_done_d = 1'b1;
          rsp_err_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      size_q     <= '0;
      burst_q    <= 1'b0;
      first_q    <= 1'b0;
      held_q     <= 1'b0;
      dphase_q   <= 1'b0;
      wbuf_q     <= '0;
      hwdata_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rsp_done_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      first_q    <= first_d;
      held_q     <= held_d;
      dphase_q   <= dphase_d;
      wbuf_q     <= wbuf_d;
      hwdata_q   <= hwdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rsp_done_q <= rsp_done_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign CMD_READY = (state_q == ST_IDLE);
  assign WR_READY  = wr_pop;
  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign RSP_DONE  = rsp_done_q;
  assign RSP_ERR   = rsp_err_q;
  assign HTRANS    = htrans;
  assign HSEL      = (htrans != HTRANS_IDLE) || dphase_q;
  assign HADDR     = ag_addr;
  assign HWRITE    = write_q;
  assign HSIZE     = size_q;
  assign HBURST    = burst_q ? HBURST_INCR : HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_DEFAULT;
  assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed cycle-by-cycle bench for ahb_cmd_master; the bench drives the slave side.
module tb_ahb_cmd_master;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        HCLK, HRESETN;
  logic        CMD_VALID, CMD_READY, CMD_WRITE;
  logic [9:0]  CMD_ADDR;
  logic [2:0]  CMD_SIZE;
  logic [3:0]  CMD_LEN;
  logic [31:0] WR_DATA;
  logic        WR_VALID, WR_READY;
  logic [31:0] RD_DATA;
  logic        RD_VALID, RSP_DONE, RSP_ERR;
  logic        HSEL, HWRITE, HMASTLOCK;
  logic [9:0]  HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;

  int unsigned errors = 0;
  int unsigned checks = 0;

  ahb_cmd_master #(.AWIDTH(10), .LENW(4)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_SIZE(CMD_SIZE), .CMD_LEN(CMD_LEN),
    .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RSP_DONE(RSP_DONE), .RSP_ERR(RSP_ERR),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus(input string tag, input logic [1:0] tr, input logic [31:0] ad,
                     input logic sel);
    chk({tag, ".htrans"}, 32'(HTRANS), 32'(tr));
    if (tr != T_IDLE) chk({tag, ".haddr"}, 32'(HADDR), ad);
    chk({tag, ".hsel"}, 32'(HSEL), 32'(sel));
  endtask

  task automatic rdv(input string tag, input logic v, input logic [31:0] d);
    chk({tag, ".rd_valid"}, 32'(RD_VALID), 32'(v));
    if (v) chk({tag, ".rd_data"}, RD_DATA, d);
  endtask

  task automatic done(input string tag, input logic d, input logic e);
    chk({tag, ".rsp_done"}, 32'(RSP_DONE), 32'(d));
    if (d) chk({tag, ".rsp_err"}, 32'(RSP_ERR), 32'(e));
  endtask

  task automatic cmd(input logic w, input logic [9:0] a, input logic [2:0] s,
                     input logic [3:0] l);
    CMD_VALID = 1'b1;
    CMD_WRITE = w;
    CMD_ADDR  = a;
    CMD_SIZE  = s;
    CMD_LEN   = l;
  endtask

  initial begin
    HRESETN = 1'b0; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0;
    CMD_SIZE = '0; CMD_LEN = '0; WR_DATA = '0; WR_VALID = 1'b0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;

    // Reset state
    #1;
    chk("rst.cmd_ready", 32'(CMD_READY), 32'h1);
    bus("rst", T_IDLE, 32'h0, 1'b0);
    chk("rst.haddr", 32'(HADDR), 32'h0);
    chk("rst.hwdata", HWDATA, 32'h0);
    chk("rst.wr_ready", 32'(WR_READY), 32'h0);
    rdv("rst", 1'b0, 32'h0);
    done("rst", 1'b0, 1'b0);
    chk("rst.hprot", 32'(HPROT), 32'h3);
    chk("rst.hmastlock", 32'(HMASTLOCK), 32'h0);
    nxt; nxt;
    HRESETN = 1'b1;

    // Single word write, zero wait
    nxt;
    cmd(1'b1, 10'h040, 3'd2, 4'd0); WR_VALID = 1'b1; WR_DATA = 32'h12345678;
    #1 chk("w1.cmd_ready", 32'(CMD_READY), 32'h1);
    nxt; CMD_VALID = 1'b0; #1;
    bus("w1.a", T_NS, 32'h040, 1'b1);
    chk("w1.hwrite", 32'(HWRITE), 32'h1);
    chk("w1.hburst", 32'(HBURST), 32'h0);
    chk("w1.hsize", 32'(HSIZE), 32'h2);
    chk("w1.wr_ready", 32'(WR_READY), 32'h1);
    chk("w1.cmd_ready_busy", 32'(CMD_READY), 32'h0);
    nxt; WR_VALID = 1'b0; #1;
    bus("w1.d", T_IDLE, 32'h0, 1'b1);
    chk("w1.hwdata", HWDATA, 32'h12345678);
    done("w1.d", 1'b0, 1'b0);
    nxt; #1;
    done("w1.end", 1'b1, 1'b0);
    chk("w1.end.cmd_ready", 32'(CMD_READY), 32'h1);
    bus("w1.end", T_IDLE, 32'h0, 1'b0);

    // Read 4 words, two wait states on the first data phase
    nxt;
    cmd(1'b0, 10'h100, 3'd2, 4'd3); #1;
    nxt; CMD_VALID = 1'b0; #1;
    bus("r4.a0", T_NS, 32'h100, 1'b1);
    chk("r4.hburst", 32'(HBURST), 32'h1);
    nxt; HREADY = 1'b0; #1; bus("r4.a1", T_SEQ, 32'h104, 1'b1);
    nxt; HREADY = 1'b0; #1; bus("r4.w2", T_SEQ, 32'h104, 1'b1); rdv("r4.w2", 1'b0, 32'h0);
    nxt; HREADY = 1'b1; HRDATA = 32'hD0D0_0000; #1; bus("r4.d0", T_SEQ, 32'h104, 1'b1);
    nxt; HRDATA = 32'hD1D1_1111; #1; bus("r4.a2", T_SEQ, 32'h108, 1'b1);
    rdv("r4.v0", 1'b1, 32'hD0D0_0000);
    nxt; HRDATA = 32'hD2D2_2222; #1; bus("r4.a3", T_SEQ, 32'h10C, 1'b1);
    rdv("r4.v1", 1'b1, 32'hD1D1_1111);
    nxt; HRDATA = 32'hD3D3_3333; #1; bus("r4.last", T_IDLE, 32'h0, 1'b1);
    rdv("r4.v2", 1'b1, 32'hD2D2_2222); done("r4.last", 1'b0, 1'b0);
    nxt; HRDATA = '0; #1;
    rdv("r4.v3", 1'b1, 32'hD3D3_3333); done("r4.end", 1'b1, 1'b0);
    chk("r4.end.cmd_ready", 32'(CMD_READY), 32'h1);

    // Halfword write burst wrapping past 0x3FF, producer stalls before beat 2
    nxt;
    cmd(1'b1, 10'h3FC, 3'd1, 4'd2); WR_VALID = 1'b1; WR_DATA = 32'h0000_A0A0; #1;
    nxt; CMD_VALID = 1'b0; #1;
    bus("hw.a0", T_NS, 32'h3FC, 1'b1); chk("hw.pop0", 32'(WR_READY), 32'h1);
    chk("hw.hsize", 32'(HSIZE), 32'h1);
    nxt; WR_VALID = 1'b0; #1;
    bus("hw.busy1", T_BUSY, 32'h3FE, 1'b1); chk("hw.busy1.wr_ready", 32'(WR_READY), 32'h0);
    chk("hw.hwdata0", HWDATA, 32'h0000_A0A0);
    nxt; #1; bus("hw.busy2", T_BUSY, 32'h3FE, 1'b1);
    nxt; WR_VALID = 1'b1; WR_DATA = 32'h0000_A1A1; #1;
    bus("hw.a1", T_SEQ, 32'h3FE, 1'b1); chk("hw.pop1", 32'(WR_READY), 32'h1);
    nxt; WR_DATA = 32'h0000_A2A2; #1;
    bus("hw.a2wrap", T_SEQ, 32'h000, 1'b1); chk("hw.hwdata1", HWDATA, 32'h0000_A1A1);
    nxt; WR_VALID = 1'b0; #1;
    bus("hw.last", T_IDLE, 32'h0, 1'b1); chk("hw.hwdata2", HWDATA, 32'h0000_A2A2);
    nxt; #1; done("hw.end", 1'b1, 1'b0);

    // Read 4 beats, beat 2 answers ERROR
    nxt;
    cmd(1'b0, 10'h200, 3'd2, 4'd3); #1;
    nxt; CMD_VALID = 1'b0; #1; bus("er.a0", T_NS, 32'h200, 1'b1);
    nxt; HRDATA = 32'hE0E0_E0E0; #1; bus("er.a1", T_SEQ, 32'h204, 1'b1);
    nxt; HRESP = 1'b1; HREADY = 1'b0; HRDATA = 32'hBAD0_BAD0; #1;
    bus("er.cyc1", T_IDLE, 32'h0, 1'b1); rdv("er.v0", 1'b1, 32'hE0E0_E0E0);
    nxt; HRESP = 1'b1; HREADY = 1'b1; #1;
    bus("er.cyc2", T_IDLE, 32'h0, 1'b1); rdv("er.cyc2", 1'b0, 32'h0); done("er.cyc2", 1'b0, 1'b0);
    nxt; HRESP = 1'b0; HRDATA = '0; #1;
    done("er.end", 1'b1, 1'b1); rdv("er.end", 1'b0, 32'h0);
    bus("er.end", T_IDLE, 32'h0, 1'b0);
    nxt; #1; bus("er.after", T_IDLE, 32'h0, 1'b0); done("er.after", 1'b0, 1'b0);

    // Reset in the middle of an 8-beat read burst
    cmd(1'b0, 10'h080, 3'd2, 4'd7); #1;
    nxt; CMD_VALID = 1'b0; #1; bus("rb.a0", T_NS, 32'h080, 1'b1);
    nxt; HRDATA = 32'hC0C0_C0C0; #1; bus("rb.a1", T_SEQ, 32'h084, 1'b1);
    nxt; #1; bus("rb.a2", T_SEQ, 32'h088, 1'b1); rdv("rb.v0", 1'b1, 32'hC0C0_C0C0);
    HRESETN = 1'b0; #1;
    chk("rb.rst.cmd_ready", 32'(CMD_READY), 32'h1);
    bus("rb.rst", T_IDLE, 32'h0, 1'b0);
    chk("rb.rst.haddr", 32'(HADDR), 32'h0);
    chk("rb.rst.hburst", 32'(HBURST), 32'h0);
    chk("rb.rst.hsize", 32'(HSIZE), 32'h0);
    chk("rb.rst.rd_data", RD_DATA, 32'h0);
    rdv("rb.rst", 1'b0, 32'h0);
    nxt; HRESETN = 1'b1; HRDATA = '0;
    nxt;
    cmd(1'b1, 10'h010, 3'd0, 4'd0); WR_VALID = 1'b1; WR_DATA = 32'h0000_00A5; #1;
    nxt; CMD_VALID = 1'b0; #1;
    bus("pr.a", T_NS, 32'h010, 1'b1); chk("pr.hsize", 32'(HSIZE), 32'h0);
    chk("pr.hburst", 32'(HBURST), 32'h0);
    nxt; WR_VALID = 1'b0; #1; chk("pr.hwdata", HWDATA, 32'h0000_00A5);
    nxt; #1; done("pr.end", 1'b1, 1'b0);

    // Back-to-back single reads
    nxt;
    cmd(1'b0, 10'h300, 3'd2, 4'd0); #1;
    nxt; CMD_ADDR = 10'h304; #1;
    bus("bb.a0", T_NS, 32'h300, 1'b1); chk("bb.a0.cmd_ready", 32'(CMD_READY), 32'h0);
    nxt; HRDATA = 32'hB0B0_B0B0; #1; bus("bb.d0", T_IDLE, 32'h0, 1'b1);
    nxt; HRDATA = '0; #1;
    bus("bb.gap", T_IDLE, 32'h0, 1'b0); done("bb.gap", 1'b1, 1'b0);
    rdv("bb.v0", 1'b1, 32'hB0B0_B0B0); chk("bb.gap.cmd_ready", 32'(CMD_READY), 32'h1);
    nxt; CMD_VALID = 1'b0; #1; bus("bb.a1", T_NS, 32'h304, 1'b1);
    nxt; HRDATA = 32'hB1B1_B1B1; #1; bus("bb.d1", T_IDLE, 32'h0, 1'b1);
    nxt; HRDATA = '0; #1; rdv("bb.v1", 1'b1, 32'hB1B1_B1B1); done("bb.end", 1'b1, 1'b0);

    nxt;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
